// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the instruction-fetch PC controller.
package fetch_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned INSTR_WIDTH_DEF = 32;
  localparam int unsigned PC_INC          = 4;
  localparam int unsigned PERF_CNT_WIDTH  = 32;

  // Fetch sequencer states: issue a request, wait for its response, or
  // swallow the response of a request made stale by a redirect.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc_ctrl_if.sv
// Redirect, I-cache and IQ signal bundle of the fetch PC controller.
// "master" is the fetch controller side, "slave" the surrounding pipeline.
interface fetch_pc_ctrl_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);

  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_target;

  logic                   fetch_req_valid;
  logic [PC_WIDTH-1:0]    fetch_req_addr;
  logic                   fetch_req_ready;
  logic                   fetch_resp_valid;
  logic [INSTR_WIDTH-1:0] fetch_resp_instr;

  logic                   iq_full;
  logic                   iq_wr_en;
  logic [INSTR_WIDTH-1:0] iq_instr;
  logic [PC_WIDTH-1:0]    iq_pc;

  modport master (
    input  redirect_valid, redirect_target,
    input  fetch_req_ready, fetch_resp_valid, fetch_resp_instr,
    input  iq_full,
    output fetch_req_valid, fetch_req_addr,
    output iq_wr_en, iq_instr, iq_pc
  );

  modport slave (
    output redirect_valid, redirect_target,
    output fetch_req_ready, fetch_resp_valid, fetch_resp_instr,
    output iq_full,
    input  fetch_req_valid, fetch_req_addr,
    input  iq_wr_en, iq_instr, iq_pc
  );

endinterface : fetch_pc_ctrl_if

// File: rtl/fetch_pc_ctrl_perf_cnt.sv
// Redirect and dropped-response event counters; free-running, wrap at 2^32.
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect,
  input  logic                      drop,
  output logic [PERF_CNT_WIDTH-1:0] perf_redirects,
  output logic [PERF_CNT_WIDTH-1:0] perf_drops
);

  // Count one event per cycle on each strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirects <= '0;
      perf_drops     <= '0;
    end else begin
      if (redirect) perf_redirects <= perf_redirects + PERF_CNT_WIDTH'(1);
      if (drop)     perf_drops     <= perf_drops + PERF_CNT_WIDTH'(1);
    end
  end

endmodule : fetch_perf_cnt

// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch PC controller: one outstanding word-aligned I-cache
// request at a time, returned instructions written to the IQ with their PC,
// redirects flush any in-flight stale fetch.
// Optional build macro FETCH_PERF_CNT_EN adds perf_redirects/perf_drops.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned          INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
)(
  input  logic                clk,
  input  logic                rst,
  fetch_pc_ctrl_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_redirects,
  output logic [31:0]         perf_drops
`endif
);

  fetch_state_e           state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    req_pc_q;
  logic                   iq_wr_q;
  logic [INSTR_WIDTH-1:0] iq_instr_q;
  logic [PC_WIDTH-1:0]    iq_pc_q;

  logic                   req_valid_c;
  logic                   req_fire_c;
  logic [PC_WIDTH-1:0]    redirect_pc_c;
  logic                   unused_tgt_bits;

  // Target low bits are meaningless for word fetch.
  assign unused_tgt_bits = ^bus.redirect_target[1:0];
  assign redirect_pc_c   = {bus.redirect_target[PC_WIDTH-1:2], 2'b00};

  // Only S_REQ issues; a full IQ holds off new requests (slot reserved at issue).
  assign req_valid_c = (state_q == S_REQ) && !bus.iq_full && !rst;
  assign req_fire_c  = req_valid_c && bus.fetch_req_ready;

  assign bus.fetch_req_valid = req_valid_c;
  assign bus.fetch_req_addr  = rst ? '0 : pc_q;
  // A same-cycle redirect flushes the IQ, so the pending write is killed.
  assign bus.iq_wr_en        = iq_wr_q && !bus.redirect_valid;
  assign bus.iq_instr        = iq_instr_q;
  assign bus.iq_pc           = iq_pc_q;

  // Fetch sequencer, PC and IQ write registers; redirect overrides the PC last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= {RESET_PC[PC_WIDTH-1:2], 2'b00};
      req_pc_q   <= '0;
      iq_wr_q    <= 1'b0;
      iq_instr_q <= '0;
      iq_pc_q    <= '0;
    end else begin
      iq_wr_q <= 1'b0;
      case (state_q)
        S_REQ: begin
          if (req_fire_c) begin
            req_pc_q <= pc_q;
            // Accepted in the redirect cycle: its response is already stale.
            state_q  <= bus.redirect_valid ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.fetch_resp_valid) begin
            state_q <= S_REQ;
            if (!bus.redirect_valid) begin
              iq_wr_q    <= 1'b1;
              iq_instr_q <= bus.fetch_resp_instr;
              iq_pc_q    <= req_pc_q;
              pc_q       <= req_pc_q + PC_WIDTH'(PC_INC);
            end
          end else if (bus.redirect_valid) begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (bus.fetch_resp_valid) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
      if (bus.redirect_valid) pc_q <= redirect_pc_c;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic resp_drop_c;

  // Responses discarded: stale ones, or those racing a redirect.
  assign resp_drop_c = bus.fetch_resp_valid &&
                       ((state_q == S_DROP) ||
                        ((state_q == S_WAIT) && bus.redirect_valid));

  fetch_perf_cnt u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .redirect       (bus.redirect_valid),
    .drop           (resp_drop_c),
    .perf_redirects (perf_redirects),
    .perf_drops     (perf_drops)
  );
`endif

endmodule : fetch_pc_ctrl

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed cycle table, reset sequence, then
// randomized traffic against a transaction-level reference model.
module tb_fetch_pc_ctrl;

  localparam int unsigned PW = 32;
  localparam int unsigned IW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_drops;
`endif

  fetch_pc_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects (perf_redirects),
    .perf_drops     (perf_drops)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic rd, input logic [31:0] tgt, input logic rdy,
                       input logic full, input logic rv, input logic [31:0] ri);
    bus.redirect_valid   = rd;
    bus.redirect_target  = tgt;
    bus.fetch_req_ready  = rdy;
    bus.iq_full          = full;
    bus.fetch_resp_valid = rv;
    bus.fetch_resp_instr = ri;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] tgt;
    logic        rdy;
    logic        full;
    logic        rv;
    logic [31:0] ri;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rd, input logic [31:0] tgt, input logic rdy, input logic full,
                     input logic rv, input logic [31:0] ri, input logic e_rv,
                     input logic [31:0] e_addr, input logic e_wr, input logic [31:0] e_pc,
                     input logic [31:0] e_instr);
    vec_t v;
    v = '{rd, tgt, rdy, full, rv, ri, e_rv, e_addr, e_wr, e_pc, e_instr};
    tbl.push_back(v);
  endtask

  // Reference model: one outstanding request, tagged stale when a redirect
  // overtakes it; a good response becomes an IQ write one cycle later.
  logic [31:0] m_pc;
  logic        m_pend;
  logic        m_stale;
  logic [31:0] m_pend_pc;
  logic        m_wr;
  logic [31:0] m_wr_pc;
  logic [31:0] m_wr_instr;
  int unsigned m_redir;
  int unsigned m_drops;

  initial begin
    logic [31:0] bad;
    bad = 32'hDEAD_BEEF;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;

    // Directed cycles: rd tgt rdy full rv ri | req_valid addr wr iq_pc iq_instr
    add(0, 0, 1, 0, 0, 0,            1, 32'h0,    0, 0, 0);
    add(0, 0, 0, 0, 1, 32'hA000_0000, 0, 32'h0,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0,            1, 32'h4,    1, 32'h0, 32'hA000_0000);
    add(0, 0, 0, 0, 1, 32'hA000_0001, 0, 32'h4,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0,            1, 32'h8,    1, 32'h4, 32'hA000_0001);
    add(0, 0, 0, 0, 1, 32'hA000_0002, 0, 32'h8,   0, 0, 0);
    add(0, 0, 1, 1, 0, 0,            0, 32'hC,    1, 32'h8, 32'hA000_0002);
    add(0, 0, 1, 1, 0, 0,            0, 32'hC,    0, 0, 0);
    add(0, 0, 1, 1, 0, 0,            0, 32'hC,    0, 0, 0);
    add(0, 0, 1, 1, 0, 0,            0, 32'hC,    0, 0, 0);
    add(0, 0, 1, 1, 0, 0,            0, 32'hC,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0,            1, 32'hC,    0, 0, 0);
    add(1, 32'h1003, 0, 0, 0, 0,     0, 32'hC,    0, 0, 0);
    add(0, 0, 0, 0, 0, 0,            0, 32'h1000, 0, 0, 0);
    add(0, 0, 0, 0, 1, bad,          0, 32'h1000, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,            1, 32'h1000, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'hB000_0000, 0, 32'h1000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,            1, 32'h1004, 1, 32'h1000, 32'hB000_0000);
    add(1, 32'h40, 0, 0, 0, 0,       1, 32'h1004, 0, 0, 0);
    add(1, 32'h200, 1, 0, 0, 0,      1, 32'h40,   0, 0, 0);
    add(0, 0, 0, 0, 1, bad,          0, 32'h200,  0, 0, 0);
    add(0, 0, 1, 0, 0, 0,            1, 32'h200,  0, 0, 0);
    add(0, 0, 0, 0, 1, 32'hC000_0000, 0, 32'h200, 0, 0, 0);
    add(1, 32'h300, 0, 0, 0, 0,      1, 32'h204,  0, 0, 0);
    add(0, 0, 1, 0, 0, 0,            1, 32'h300,  0, 0, 0);
    add(0, 0, 0, 0, 1, 32'hC000_0001, 0, 32'h300, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,            1, 32'h304,  1, 32'h300, 32'hC000_0001);
    add(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 32'h304, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'hD000_0000, 0, 32'hFFFF_FFFC, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,            1, 32'h0,    1, 32'hFFFF_FFFC, 32'hD000_0000);
    add(0, 0, 1, 0, 0, 0,            1, 32'h0,    0, 0, 0);
    add(1, 32'h500, 0, 0, 1, bad,    0, 32'h0,    0, 0, 0);
    add(0, 0, 0, 0, 0, 0,            1, 32'h500,  0, 0, 0);

    // Outputs held low in reset even with a non-full IQ.
    repeat (2) @(negedge clk);
    #1;
    check("rst req_valid", 32'(bus.fetch_req_valid), 32'h0);
    check("rst req_addr", bus.fetch_req_addr, 32'h0);
    check("rst iq_wr_en", 32'(bus.iq_wr_en), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rd, tbl[i].tgt, tbl[i].rdy, tbl[i].full, tbl[i].rv, tbl[i].ri);
      #1;
      check($sformatf("row%0d req_valid", i), 32'(bus.fetch_req_valid), 32'(tbl[i].e_rv));
      check($sformatf("row%0d req_addr", i), bus.fetch_req_addr, tbl[i].e_addr);
      check($sformatf("row%0d iq_wr_en", i), 32'(bus.iq_wr_en), 32'(tbl[i].e_wr));
      if (tbl[i].e_wr) begin
        check($sformatf("row%0d iq_pc", i), bus.iq_pc, tbl[i].e_pc);
        check($sformatf("row%0d iq_instr", i), bus.iq_instr, tbl[i].e_instr);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    check("table perf_redirects", perf_redirects, 32'd6);
    check("table perf_drops", perf_drops, 32'd3);
`endif

    // Reset with a request in flight returns everything to reset values.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check("pre-rst req_addr", bus.fetch_req_addr, 32'h500);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst req_valid", 32'(bus.fetch_req_valid), 32'h0);
    check("midrst iq_pc", bus.iq_pc, 32'h0);
    check("midrst iq_instr", bus.iq_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("midrst perf_redirects", perf_redirects, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post-rst req_valid", 32'(bus.fetch_req_valid), 32'h1);
    check("post-rst req_addr", bus.fetch_req_addr, 32'h0);

    // Randomized traffic against the model with a variable-latency cache.
    m_pc = 32'h0; m_pend = 1'b0; m_stale = 1'b0; m_pend_pc = 32'h0;
    m_wr = 1'b0; m_wr_pc = 32'h0; m_wr_instr = 32'h0; m_redir = 0; m_drops = 0;
    begin
      logic        c_busy;
      int unsigned c_cnt;
      c_busy = 1'b0;
      c_cnt  = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        logic rd, rdy, full, rv, e_rv, e_wr, fire;
        logic [31:0] tgt, ri;
        @(negedge clk);
        rd   = ($urandom_range(7) == 0);
        tgt  = $urandom;
        rdy  = ($urandom_range(3) != 0);
        full = ($urandom_range(4) == 0);
        rv   = c_busy && (c_cnt == 0);
        ri   = $urandom;
        drive(rd, tgt, rdy, full, rv, ri);
        #1;
        e_rv = !m_pend && !full;
        e_wr = m_wr && !rd;
        check($sformatf("rnd%0d req_valid", cyc), 32'(bus.fetch_req_valid), 32'(e_rv));
        check($sformatf("rnd%0d req_addr", cyc), bus.fetch_req_addr, m_pc);
        check($sformatf("rnd%0d iq_wr_en", cyc), 32'(bus.iq_wr_en), 32'(e_wr));
        if (e_wr) begin
          check($sformatf("rnd%0d iq_pc", cyc), bus.iq_pc, m_wr_pc);
          check($sformatf("rnd%0d iq_instr", cyc), bus.iq_instr, m_wr_instr);
        end
        // Advance model across the clock edge.
        fire = e_rv && rdy;
        m_wr = 1'b0;
        if (m_pend && rv) begin
          if (!m_stale && !rd) begin
            m_wr       = 1'b1;
            m_wr_pc    = m_pend_pc;
            m_wr_instr = ri;
            m_pc       = m_pend_pc + 32'd4;
          end else begin
            m_drops++;
          end
          m_pend = 1'b0;
        end
        if (fire) begin
          m_pend    = 1'b1;
          m_pend_pc = m_pc;
          m_stale   = 1'b0;
        end
        if (rd) begin
          if (m_pend) m_stale = 1'b1;
          m_pc = tgt & 32'hFFFF_FFFC;
          m_redir++;
        end
        if (rv) c_busy = 1'b0;
        else if (c_busy) c_cnt--;
        if (fire) begin
          c_busy = 1'b1;
          c_cnt  = $urandom_range(2);
        end
      end
    end
`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    check("rnd perf_redirects", perf_redirects, m_redir);
    check("rnd perf_drops", perf_drops, m_drops);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_fetch_pc_ctrl
